// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, fetch state encodings and NOP word shared by the fetch stage.
package fetch_unit_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;
    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_VALID  = 2'd1;
    localparam logic [1:0] S_HALT   = 2'd2;
    localparam logic [31:0] NOP_WORD = 32'h0;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem req/ack fetcher presenting one instruction per cycle to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        hazard_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        stall_b,
    output logic        halted
);
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d;
    logic        squash_q, squash_d;
    logic        is_fetch, is_valid, is_halt_op, load;

    assign is_fetch    = state_q == S_FETCH;
    assign is_valid    = state_q == S_VALID;
    assign is_halt_op  = instr_q[31:26] == HALT_OPCODE;
    assign stall_b     = is_valid && !hazard_stall;
    // a squashed request must not be re-driven at the new pc until its ack drains
    assign imem_req    = rst_b && ((is_fetch && !squash_q) || (stall_b && !is_halt_op));
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign halted      = state_q == S_HALT;
    assign load        = imem_ack && imem_req;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        squash_d = squash_q;
        if (!halted && redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            state_d  = S_FETCH;
            squash_d = (imem_req || squash_q) && !imem_ack;
        end else if (load) begin
            instr_d  = imem_data;
            pc_out_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_VALID;
        end else if (is_fetch && imem_ack) begin
            squash_d = 1'b0;
        end else if (stall_b) begin
            state_d = is_halt_op ? S_HALT : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_out_q <= 32'h0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            squash_q <= squash_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests of fetch_unit against zero-wait and 3-cycle memory models.
module tb_fetch_unit;
    logic        clk = 1'b0, rst_b = 1'b0, hazard_stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, imem_ack, stall_b, halted;
    logic [31:0] imem_addr, imem_data, instruction, pc_out;
    logic        zw = 1'b1, halt_en = 1'b0, busy = 1'b0;
    logic [1:0]  cnt = 2'd0;
    logic [31:0] lat_addr = 32'h0, mem_a;
    int          checks = 0, errors = 0;

    fetch_unit dut (
        .clk(clk), .rst_b(rst_b), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .hazard_stall(hazard_stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instruction(instruction),
        .pc_out(pc_out), .stall_b(stall_b), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {6'h08, a[25:0]};
    endfunction

    // memory: zero-wait acks combinationally; latency mode completes an accepted request 3 cycles later
    assign mem_a     = zw ? imem_addr : lat_addr;
    assign imem_data = (halt_en && mem_a == 32'h10) ? 32'hFC00_0000 : word(mem_a);
    assign imem_ack  = zw ? imem_req : (busy && cnt == 2'd0);

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (cnt == 2'd0) busy <= 1'b0;
            else cnt <= cnt - 2'd1;
        end else if (!zw && imem_req) begin
            busy     <= 1'b1;
            cnt      <= 2'd2;
            lat_addr <= imem_addr;
        end
    end

    task automatic do_reset(input logic z, input logic h);
        @(negedge clk);
        rst_b = 1'b0; zw = z; halt_en = h; hazard_stall = 1'b0; redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL reset_stall_b: got %b expected 0", stall_b); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction); end
    endtask

    task automatic test_zero_wait();
        do_reset(1'b1, 1'b0);
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL zw_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL zw_stall_b[%0d]: got %b expected 1", i, stall_b); end
            checks++; if (pc_out !== 32'(4 * i)) begin errors++; $display("FAIL zw_pc_out[%0d]: got %h expected %h", i, pc_out, 32'(4 * i)); end
            checks++; if (instruction !== word(32'(4 * i))) begin errors++; $display("FAIL zw_instr[%0d]: got %h expected %h", i, instruction, word(32'(4 * i))); end
        end
    endtask

    task automatic test_hazard();
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        hazard_stall = 1'b1;
        #1;
        checks++; if (stall_b !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL hz_enter: got stall_b=%b req=%b expected 0 0", stall_b, imem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (pc_out !== 32'h4 || instruction !== word(32'h4)) begin errors++; $display("FAIL hz_hold[%0d]: got pc_out=%h instr=%h expected 4 %h", i, pc_out, instruction, word(32'h4)); end
            checks++; if (stall_b !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL hz_quiet[%0d]: got stall_b=%b req=%b expected 0 0", i, stall_b, imem_req); end
        end
        hazard_stall = 1'b0;
        #1;
        checks++; if (stall_b !== 1'b1) begin errors++; $display("FAIL hz_release: got %b expected 1", stall_b); end
        @(negedge clk);
        checks++; if (pc_out !== 32'h8 || stall_b !== 1'b1) begin errors++; $display("FAIL hz_resume: got pc_out=%h stall_b=%b expected 8 1", pc_out, stall_b); end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rd_pre_addr: got %h expected 8", imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (stall_b !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rd_fetch: got stall_b=%b req=%b addr=%h expected 0 1 100", stall_b, imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (stall_b !== 1'b1 || pc_out !== 32'h100 || instruction !== word(32'h100)) begin errors++; $display("FAIL rd_target: got stall_b=%b pc_out=%h instr=%h expected 1 100 %h", stall_b, pc_out, instruction, word(32'h100)); end
    endtask

    task automatic test_squash();
        logic found;
        do_reset(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (busy && lat_addr == 32'hC) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL sq_req_c: got no request for c expected one within 100 cycles"); end
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h40 || stall_b !== 1'b0) begin errors++; $display("FAIL sq_wait: got req=%b addr=%h stall_b=%b expected 0 40 0", imem_req, imem_addr, stall_b); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_ack) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found || imem_req !== 1'b0) begin errors++; $display("FAIL sq_drop: got ack=%b req=%b expected ack=1 req=0", found, imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || stall_b !== 1'b0) begin errors++; $display("FAIL sq_refetch: got req=%b addr=%h stall_b=%b expected 1 40 0", imem_req, imem_addr, stall_b); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (stall_b) found = 1'b1;
        end
        checks++; if (!found || pc_out !== 32'h40 || instruction !== word(32'h40)) begin errors++; $display("FAIL sq_target: got valid=%b pc_out=%h instr=%h expected 1 40 %h", found, pc_out, instruction, word(32'h40)); end
    endtask

    task automatic test_halt();
        do_reset(1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (pc_out !== 32'h10 || instruction !== 32'hFC00_0000 || stall_b !== 1'b1) begin errors++; $display("FAIL halt_present: got pc_out=%h instr=%h stall_b=%b expected 10 fc000000 1", pc_out, instruction, stall_b); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_no_fetch: got %b expected 0", imem_req); end
        @(negedge clk);
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || stall_b !== 1'b0) begin errors++; $display("FAIL halt_enter: got halted=%b req=%b stall_b=%b expected 1 0 0", halted, imem_req, stall_b); end
        redirect = 1'b1; redirect_pc = 32'h200;
        repeat (2) @(negedge clk);
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || stall_b !== 1'b0 || imem_addr !== 32'h14) begin errors++; $display("FAIL halt_redirect: got halted=%b req=%b stall_b=%b addr=%h expected 1 0 0 14", halted, imem_req, stall_b, imem_addr); end
        redirect = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b0);
        @(negedge clk);
        hazard_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        hazard_stall = 1'b0; redirect = 1'b0;
        #1;
        checks++; if (stall_b !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect: got stall_b=%b req=%b addr=%h expected 0 1 fffffffc", stall_b, imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (pc_out !== 32'hFFFF_FFFC || stall_b !== 1'b1) begin errors++; $display("FAIL wrap_top: got pc_out=%h stall_b=%b expected fffffffc 1", pc_out, stall_b); end
        @(negedge clk);
        checks++; if (pc_out !== 32'h0 || instruction !== word(32'h0)) begin errors++; $display("FAIL wrap_zero: got pc_out=%h instr=%h expected 0 %h", pc_out, instruction, word(32'h0)); end
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h20) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rm_reach: got no request for 20 expected one within 200 cycles"); end
        rst_b = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || stall_b !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0) begin errors++; $display("FAIL rm_async: got req=%b stall_b=%b pc_out=%h instr=%h expected 0 0 0 0", imem_req, stall_b, pc_out, instruction); end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart: got req=%b addr=%h expected 1 0", imem_req, imem_addr); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (stall_b) found = 1'b1;
        end
        checks++; if (!found || pc_out !== 32'h0 || instruction !== word(32'h0)) begin errors++; $display("FAIL rm_first: got valid=%b pc_out=%h instr=%h expected 1 0 %h", found, pc_out, instruction, word(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_hazard();
        test_redirect();
        test_squash();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
